// File: rtl/uart_mmio_fifo_if.sv
// CPU-side bus and UART-side handshakes for uart_mmio_fifo.
// master = CPU/UART pair driving the block, slave = the block itself.
interface uart_mmio_fifo_if #(
    parameter int DATA_W = 8
);
    logic              stall;
    logic              sel;
    logic [3:0]        addr;
    logic              wr_en;
    logic              rd_en;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (
        output stall, sel, addr, wr_en, rd_en, wdata, tx_ready, rx_data, rx_valid,
        input  rdata, tx_data, tx_valid, rx_ready
    );

    modport slave (
        input  stall, sel, addr, wr_en, rd_en, wdata, tx_ready, rx_data, rx_valid,
        output rdata, tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART block with TX/RX FIFOs, sticky error flags and a cycle counter.
// Optional TX->RX loopback is built only when UART_LOOPBACK_EN is defined.
module uart_mmio_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    uart_mmio_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [3:0] ADDR_TX_STAT = 4'd0;
    localparam logic [3:0] ADDR_RX_STAT = 4'd1;
    localparam logic [3:0] ADDR_TX_DATA = 4'd2;
    localparam logic [3:0] ADDR_RX_DATA = 4'd3;
    localparam logic [3:0] ADDR_CYCLE   = 4'd4;
    localparam logic [3:0] ADDR_CTRL    = 4'd5;

    logic access;
    logic rd_acc;
    logic wr_acc;
    logic ctrl_wr;
    logic flag_clr;
    logic cnt_clr;

    logic [DATA_W-1:0] tx_mem [DEPTH];
    logic [PTR_W-1:0]  tx_wr_ptr;
    logic [PTR_W-1:0]  tx_rd_ptr;
    logic [CNT_W-1:0]  tx_count;
    logic              tx_full;
    logic              tx_empty;
    logic              tx_push_req;
    logic              tx_push;
    logic              tx_pop;
    logic              tx_drop_set;
    logic              tx_drop;
    logic [DATA_W-1:0] tx_head;

    logic [DATA_W-1:0] rx_mem [DEPTH];
    logic [PTR_W-1:0]  rx_wr_ptr;
    logic [PTR_W-1:0]  rx_rd_ptr;
    logic [CNT_W-1:0]  rx_count;
    logic              rx_full;
    logic              rx_empty;
    logic              rx_push;
    logic              rx_pop;
    logic              rx_ovf_set;
    logic              rx_ovf;
    logic [DATA_W-1:0] rx_push_data;

    logic              loopback;
    logic              lb_move;
    logic [31:0]       cycle_cnt;
    logic [31:0]       read_word;
    logic [31:0]       rdata_q;
    logic              unused_wdata;

    assign access   = bus.sel & ~bus.stall & (bus.rd_en | bus.wr_en);
    assign rd_acc   = access & bus.rd_en;
    assign wr_acc   = access & bus.wr_en;
    assign ctrl_wr  = wr_acc & (bus.addr == ADDR_CTRL);
    assign flag_clr = ctrl_wr & bus.wdata[0];
    assign cnt_clr  = wr_acc & (bus.addr == ADDR_CYCLE);
    assign unused_wdata = ^bus.wdata[31:DATA_W];

`ifdef UART_LOOPBACK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            loopback <= 1'b0;
        end else if (ctrl_wr) begin
            loopback <= bus.wdata[1];
        end
    end

    assign lb_move = loopback & ~tx_empty & ~rx_full;
`else
    assign loopback = 1'b0;
    assign lb_move  = 1'b0;
`endif

    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                    input logic push, input logic pop);
        logic [CNT_W-1:0] res;
        res = cnt;
        if (push && !pop) begin
            res = cnt + CNT_W'(1);
        end else if (pop && !push) begin
            res = cnt - CNT_W'(1);
        end
        return res;
    endfunction

    // TX side: a pop frees a slot on the same edge, so a full FIFO can still accept a write
    assign tx_full     = (tx_count == FULL_CNT);
    assign tx_empty    = (tx_count == '0);
    assign tx_head     = tx_mem[tx_rd_ptr];
    assign bus.tx_valid = rst & ~tx_empty & ~loopback;
    assign bus.tx_data  = tx_head;
    assign tx_pop      = lb_move | (bus.tx_valid & bus.tx_ready);
    assign tx_push_req = wr_acc & (bus.addr == ADDR_TX_DATA);
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);
    assign tx_drop_set = tx_push_req & tx_full & ~tx_pop;

    assign rx_full      = (rx_count == FULL_CNT);
    assign rx_empty     = (rx_count == '0);
    assign bus.rx_ready = rst & ~rx_full & ~loopback;
    assign rx_push      = lb_move | (bus.rx_valid & bus.rx_ready);
    assign rx_push_data = lb_move ? tx_head : bus.rx_data;
    assign rx_pop       = rd_acc & (bus.addr == ADDR_RX_DATA) & ~rx_empty;
    assign rx_ovf_set   = bus.rx_valid & ~bus.rx_ready;

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= bus.wdata[DATA_W-1:0];
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
            tx_count <= next_count(tx_count, tx_push, tx_pop);
            rx_count <= next_count(rx_count, rx_push, rx_pop);
        end
    end

    // A set event in the same cycle as a clear leaves the flag set
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_drop   <= 1'b0;
            rx_ovf    <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            tx_drop   <= tx_drop_set | (tx_drop & ~flag_clr);
            rx_ovf    <= rx_ovf_set | (rx_ovf & ~flag_clr);
            cycle_cnt <= cnt_clr ? 32'd0 : cycle_cnt + 32'd1;
        end
    end

    always_comb begin
        read_word = '0;
        case (bus.addr)
            ADDR_TX_STAT: read_word = {14'b0, tx_drop, 1'b0, 8'(tx_count), 7'b0, ~tx_full};
            ADDR_RX_STAT: read_word = {13'b0, loopback, 1'b0, rx_ovf, 8'(rx_count), 7'b0, ~rx_empty};
            ADDR_RX_DATA: read_word = rx_empty ? 32'd0 : 32'(rx_mem[rx_rd_ptr]);
            ADDR_CYCLE:   read_word = cycle_cnt;
            default:      read_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (rd_acc) begin
            rdata_q <= read_word;
        end
    end

    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Self-checking bench for uart_mmio_fifo: queue-based reference model plus directed vectors.
// Loopback vectors are included when UART_LOOPBACK_EN is defined.
module tb_uart_mmio_fifo;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    uart_mmio_fifo_if #(.DATA_W(DATA_W)) bus ();

    uart_mmio_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [7:0]  m_tx_q[$];
    logic [7:0]  m_rx_q[$];
    logic [7:0]  dut_sent[$];
    bit          m_tx_drop;
    bit          m_rx_ovf;
    bit          m_lb;
    logic [31:0] m_cycles;
    logic [31:0] m_rdata;
    bit          model_live = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        int tx_n = m_tx_q.size();
        int rx_n = m_rx_q.size();
        case (a)
            4'd0: return (32'(m_tx_drop) << 17) + (32'(tx_n) << 8) + 32'(tx_n < DEPTH);
            4'd1: return (32'(m_lb) << 18) + (32'(m_rx_ovf) << 16) + (32'(rx_n) << 8) + 32'(rx_n > 0);
            4'd3: return (rx_n > 0) ? 32'(m_rx_q[0]) : 32'd0;
            4'd4: return m_cycles;
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: pre-edge state decides every outcome, then queues are updated
    always @(posedge clk) begin
        bit acc, rd, wr, tx_go, move, rx_take, rd_pop;
        logic [7:0] moved, junk;
        if (!rst) begin
            m_tx_q.delete();
            m_rx_q.delete();
            m_tx_drop  = 1'b0;
            m_rx_ovf   = 1'b0;
            m_lb       = 1'b0;
            m_cycles   = 32'd0;
            m_rdata    = 32'd0;
            model_live = 1'b1;
        end else begin
            acc     = bus.sel && !bus.stall && (bus.rd_en || bus.wr_en);
            rd      = acc && bus.rd_en;
            wr      = acc && bus.wr_en;
            if (rd) m_rdata = model_read(bus.addr);
            tx_go   = !m_lb && m_tx_q.size() > 0 && bus.tx_ready;
            move    = m_lb && m_tx_q.size() > 0 && m_rx_q.size() < DEPTH;
            rx_take = !m_lb && bus.rx_valid && m_rx_q.size() < DEPTH;
            rd_pop  = rd && bus.addr == 4'd3 && m_rx_q.size() > 0;
            if (wr && bus.addr == 4'd5 && bus.wdata[0]) begin
                m_tx_drop = 1'b0;
                m_rx_ovf  = 1'b0;
            end
            if (bus.rx_valid && !rx_take) m_rx_ovf = 1'b1;
            moved = 8'h00;
            if (tx_go || move) moved = m_tx_q.pop_front();
            if (wr && bus.addr == 4'd2) begin
                if (m_tx_q.size() < DEPTH) m_tx_q.push_back(bus.wdata[7:0]);
                else m_tx_drop = 1'b1;
            end
            if (rd_pop) junk = m_rx_q.pop_front();
            if (rx_take) m_rx_q.push_back(bus.rx_data);
            if (move) m_rx_q.push_back(moved);
            m_cycles = (wr && bus.addr == 4'd4) ? 32'd0 : m_cycles + 32'd1;
`ifdef UART_LOOPBACK_EN
            if (wr && bus.addr == 4'd5) m_lb = bus.wdata[1];
`endif
        end
    end

    always @(posedge clk) begin
        if (rst && bus.tx_valid && bus.tx_ready) dut_sent.push_back(bus.tx_data);
    end

    always @(negedge clk) begin
        bit exp_tv, exp_rr;
        if (model_live) begin
            exp_tv = rst && !m_lb && m_tx_q.size() > 0;
            exp_rr = rst && !m_lb && m_rx_q.size() < DEPTH;
            check_output("rdata", bus.rdata, m_rdata);
            check_output("tx_valid", 32'(bus.tx_valid), 32'(exp_tv));
            check_output("rx_ready", 32'(bus.rx_ready), 32'(exp_rr));
            if (exp_tv) check_output("tx_data", 32'(bus.tx_data), 32'(m_tx_q[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.sel   = 1'b0;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.stall = 1'b0;
        bus.addr  = 4'd0;
        bus.wdata = 32'd0;
    endtask

    task automatic apply_stimulus(input logic rd, input logic wr, input logic [3:0] a,
                                  input logic [31:0] d, input logic stall);
        bus.sel   = 1'b1;
        bus.rd_en = rd;
        bus.wr_en = wr;
        bus.addr  = a;
        bus.wdata = d;
        bus.stall = stall;
        tick();
        idle_bus();
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        apply_stimulus(1'b0, 1'b1, a, d, 1'b0);
    endtask

    task automatic read_expect(input string name, input logic [3:0] a, input logic [31:0] exp);
        apply_stimulus(1'b1, 1'b0, a, 32'd0, 1'b0);
        check_output(name, bus.rdata, exp);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b0;
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        idle_bus();
        tick();
        tick();
        check_output("reset_rdata", bus.rdata, 32'd0);
        check_output("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
        check_output("reset_rx_ready", 32'(bus.rx_ready), 32'd0);
        rst = 1'b1;
        #1;
        check_output("release_rx_ready", 32'(bus.rx_ready), 32'd1);
        read_expect("rx_status_after_reset", 4'd1, 32'h0000_0000);

        // Nine writes into an 8-deep TX FIFO with the transmitter stalled
        for (int i = 0; i < 9; i++) bus_write(4'd2, 32'h41 + 32'(i));
        read_expect("tx_status_full_drop", 4'd0, 32'h0002_0800);
        bus.tx_ready = 1'b1;
        repeat (10) tick();
        check_output("tx_sent_count", 32'(dut_sent.size()), 32'd8);
        for (int i = 0; i < 8 && i < dut_sent.size(); i++)
            check_output("tx_sent_byte", 32'(dut_sent[i]), 32'h41 + 32'(i));
        read_expect("tx_status_drained", 4'd0, 32'h0002_0001);
        bus_write(4'd5, 32'h1);
        read_expect("tx_status_cleared", 4'd0, 32'h0000_0001);

        // Full FIFO with a same-cycle pop accepts the write without a drop
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) bus_write(4'd2, 32'h60 + 32'(i));
        bus.tx_ready = 1'b1;
        bus_write(4'd2, 32'h68);
        repeat (10) tick();
        check_output("tx_full_pop_count", 32'(dut_sent.size()), 32'd17);
        if (dut_sent.size() > 0)
            check_output("tx_full_pop_last", 32'(dut_sent[dut_sent.size()-1]), 32'h68);
        read_expect("tx_status_no_drop", 4'd0, 32'h0000_0001);

        for (int i = 0; i < 9; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'h10 + 8'(i);
            tick();
            if (i == 7) check_output("rx_ready_after_8", 32'(bus.rx_ready), 32'd0);
        end
        bus.rx_valid = 1'b0;
        read_expect("rx_status_full_ovf", 4'd1, 32'h0001_0801);
        apply_stimulus(1'b1, 1'b0, 4'd3, 32'd0, 1'b1);
        check_output("stalled_read_holds", bus.rdata, 32'h0001_0801);
        for (int i = 0; i < 8; i++) read_expect("rx_pop_byte", 4'd3, 32'h10 + 32'(i));
        read_expect("rx_pop_empty", 4'd3, 32'h0);

        // Empty RX with a same-cycle push and read: read returns 0, byte is kept
        bus_write(4'd5, 32'h1);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h77;
        apply_stimulus(1'b1, 1'b0, 4'd3, 32'd0, 1'b0);
        bus.rx_valid = 1'b0;
        check_output("rx_push_read_empty", bus.rdata, 32'h0);
        read_expect("rx_status_one", 4'd1, 32'h0000_0101);
        read_expect("rx_pop_pushed", 4'd3, 32'h77);

        apply_stimulus(1'b0, 1'b1, 4'd2, 32'h99, 1'b1);
        read_expect("stalled_write_ignored", 4'd0, 32'h0000_0001);
        read_expect("unmapped_offset", 4'd7, 32'h0);

        bus_write(4'd4, 32'h0);
        tick();
        read_expect("counter_after_clear", 4'd4, 32'd1);
        bus_write(4'd4, 32'h0);
        repeat (100) tick();
        read_expect("counter_100", 4'd4, 32'd100);

`ifdef UART_LOOPBACK_EN
        bus_write(4'd5, 32'h2);
        bus_write(4'd2, 32'h5A);
        check_output("lb_tx_valid_low", 32'(bus.tx_valid), 32'd0);
        tick();
        read_expect("lb_rx_status", 4'd1, 32'h0004_0101);
        read_expect("lb_rx_byte", 4'd3, 32'h5A);
        bus_write(4'd5, 32'h0);
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
